// File: rtl/conv_row_mac.sv
// Per-kernel MAC for the first conv layer: NK signed dot products per beat,
// accumulated over ROWS beats, emitted as one NK-lane vector with a one-cycle valid pulse.
module conv_row_mac #(
    parameter int NK    = 32,
    parameter int TAPS  = 7,
    parameter int ROWS  = 7,
    parameter int DW    = 8,
    parameter int ACC_W = 24
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   conv_en,
    input  logic [TAPS*NK*DW-1:0]  conv_weight,
    input  logic [TAPS*DW-1:0]     pixel,
    input  logic                   flush,
    output logic [NK*ACC_W-1:0]    sum_out,
    output logic                   sum_valid,
    output logic                   busy,
    output logic [3:0]             beat_cnt
);

    localparam int PW = 2*DW + 1;
    localparam int RW = PW + $clog2(TAPS);
    localparam logic [3:0] LAST_BEAT = 4'(ROWS - 1);

    logic                    accept;
    logic [3:0]              cnt_q;
    logic                    s1_valid_q, s1_first_q, s1_last_q;
    logic                    s2_valid_q, s2_first_q;
    logic                    s2_last_q;
    logic                    s3_valid_q, s3_last_q;
    logic signed [PW-1:0]    prod_d [NK][TAPS];
    logic signed [PW-1:0]    prod_q [NK][TAPS];
    logic signed [RW-1:0]    rsum_d [NK];
    logic signed [RW-1:0]    rsum_q [NK];
    logic signed [ACC_W-1:0] acc_q  [NK];
    logic [NK*ACC_W-1:0]     sum_out_q;
    logic                    sum_valid_q;

    assign accept = conv_en && !flush;

    // Pixels are unsigned, so a zero MSB keeps them positive in the signed multiply.
    always_comb begin
        for (int n = 0; n < NK; n++) begin
            for (int t = 0; t < TAPS; t++) begin
                prod_d[n][t] = $signed({1'b0, pixel[DW*t +: DW]})
                             * $signed(conv_weight[DW*(TAPS*n+t) +: DW]);
            end
        end
    end

    always_comb begin
        for (int n = 0; n < NK; n++) begin
            rsum_d[n] = '0;
            for (int t = 0; t < TAPS; t++) begin
                rsum_d[n] = rsum_d[n] + RW'(prod_q[n][t]);
            end
        end
    end

    // Beat counter and the valid/first/last tags that travel alongside the data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_first_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_first_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            s3_valid_q  <= 1'b0;
            s3_last_q   <= 1'b0;
            sum_valid_q <= 1'b0;
        end else if (flush) begin
            cnt_q       <= '0;
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            s3_valid_q  <= 1'b0;
            sum_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                cnt_q <= (cnt_q == LAST_BEAT) ? 4'd0 : cnt_q + 4'd1;
            end
            s1_valid_q  <= accept;
            s1_first_q  <= accept && (cnt_q == 4'd0);
            s1_last_q   <= accept && (cnt_q == LAST_BEAT);
            s2_valid_q  <= s1_valid_q;
            s2_first_q  <= s1_first_q;
            s2_last_q   <= s1_last_q;
            s3_valid_q  <= s2_valid_q;
            s3_last_q   <= s2_last_q;
            sum_valid_q <= s3_valid_q && s3_last_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < NK; n++) begin
                for (int t = 0; t < TAPS; t++) begin
                    prod_q[n][t] <= '0;
                end
                rsum_q[n] <= '0;
            end
        end else begin
            if (accept) begin
                prod_q <= prod_d;
            end
            if (s1_valid_q) begin
                rsum_q <= rsum_d;
            end
        end
    end

    // A first beat overwrites the accumulator, so windows can run back to back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < NK; n++) begin
                acc_q[n] <= '0;
            end
            sum_out_q <= '0;
        end else if (flush) begin
            for (int n = 0; n < NK; n++) begin
                acc_q[n] <= '0;
            end
        end else begin
            if (s2_valid_q) begin
                for (int n = 0; n < NK; n++) begin
                    acc_q[n] <= s2_first_q ? ACC_W'(rsum_q[n])
                                           : acc_q[n] + ACC_W'(rsum_q[n]);
                end
            end
            if (s3_valid_q && s3_last_q) begin
                for (int n = 0; n < NK; n++) begin
                    sum_out_q[ACC_W*n +: ACC_W] <= acc_q[n];
                end
            end
        end
    end

    assign sum_out   = sum_out_q;
    assign sum_valid = sum_valid_q;
    assign beat_cnt  = cnt_q;
    assign busy      = s1_valid_q || s2_valid_q || s3_valid_q || (cnt_q != 4'd0);

endmodule

// File: tb/tb_conv_row_mac.sv
// Directed self-checking bench for conv_row_mac with hand-computed window sums.
module tb_conv_row_mac;

    localparam int NK    = 32;
    localparam int TAPS  = 7;
    localparam int ROWS  = 7;
    localparam int DW    = 8;
    localparam int ACC_W = 24;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  conv_en;
    logic [TAPS*NK*DW-1:0] conv_weight;
    logic [TAPS*DW-1:0]    pixel;
    logic                  flush;
    logic [NK*ACC_W-1:0]   sum_out;
    logic                  sum_valid;
    logic                  busy;
    logic [3:0]            beat_cnt;

    int checks   = 0;
    int failures = 0;

    conv_row_mac #(.NK(NK), .TAPS(TAPS), .ROWS(ROWS), .DW(DW), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst_n(rst_n), .conv_en(conv_en), .conv_weight(conv_weight),
        .pixel(pixel), .flush(flush), .sum_out(sum_out), .sum_valid(sum_valid),
        .busy(busy), .beat_cnt(beat_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [TAPS*NK*DW-1:0] fillW(input logic [DW-1:0] v);
        logic [TAPS*NK*DW-1:0] r;
        for (int i = 0; i < TAPS*NK; i++) r[DW*i +: DW] = v;
        return r;
    endfunction

    function automatic logic [TAPS*DW-1:0] fillP(input logic [DW-1:0] v);
        logic [TAPS*DW-1:0] r;
        for (int i = 0; i < TAPS; i++) r[DW*i +: DW] = v;
        return r;
    endfunction

    function automatic int lane(input int n);
        logic signed [ACC_W-1:0] v;
        v = sum_out[ACC_W*n +: ACC_W];
        return int'(v);
    endfunction

    // Sampling point is 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [DW-1:0] p, input logic [DW-1:0] w);
        conv_en     = 1'b1;
        pixel       = fillP(p);
        conv_weight = fillW(w);
        step();
        conv_en     = 1'b0;
    endtask

    task automatic window(input logic [DW-1:0] p, input logic [DW-1:0] w);
        for (int i = 0; i < ROWS; i++) beat(p, w);
    endtask

    task automatic waitPulse(output int cyc);
        cyc = 0;
        while (!sum_valid && cyc < 20) begin
            step();
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; conv_en = 1'b0; flush = 1'b0;
        pixel = '0; conv_weight = '0;
        #12;
        checks++; if (sum_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_sum_valid got %b want 0", sum_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        checks++; if (beat_cnt !== 4'd0) begin failures++; $display("[TB] FAIL reset_beat_cnt got %0d want 0", beat_cnt); end
        checks++; if (sum_out !== '0) begin failures++; $display("[TB] FAIL reset_sum_out got %h want 0", sum_out); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_all_ones();
        int cyc, bad;
        for (int i = 0; i < ROWS; i++) begin
            beat(8'd1, 8'd1);
            if (i == 2) begin
                checks++; if (beat_cnt !== 4'd3) begin failures++; $display("[TB] FAIL ones_beat_cnt got %0d want 3", beat_cnt); end
                checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL ones_busy got %b want 1", busy); end
            end
        end
        waitPulse(cyc);
        checks++; if (cyc !== 3) begin failures++; $display("[TB] FAIL ones_latency got %0d want 3", cyc); end
        bad = 0;
        for (int n = 0; n < NK; n++) if (lane(n) !== 49) bad++;
        checks++; if (bad !== 0) begin failures++; $display("[TB] FAIL ones_lanes bad=%0d lane0 got %0d want 49", bad, lane(0)); end
        step();
        checks++; if (sum_valid !== 1'b0) begin failures++; $display("[TB] FAIL ones_pulse_width got %b want 0", sum_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL ones_busy_after got %b want 0", busy); end
        checks++; if (lane(5) !== 49) begin failures++; $display("[TB] FAIL ones_hold got %0d want 49", lane(5)); end
    endtask

    task automatic test_sign();
        int cyc;
        logic [TAPS*NK*DW-1:0] w;
        w = '0;
        for (int t = 0; t < TAPS; t++) begin
            w[DW*t +: DW]             = 8'h80;
            w[DW*(TAPS*31+t) +: DW]   = 8'h7F;
        end
        for (int i = 0; i < ROWS; i++) begin
            conv_en = 1'b1; pixel = fillP(8'hFF); conv_weight = w;
            step();
        end
        conv_en = 1'b0;
        waitPulse(cyc);
        checks++; if (cyc !== 3) begin failures++; $display("[TB] FAIL sign_latency got %0d want 3", cyc); end
        // 255 * -128 * 49 and 255 * 127 * 49
        checks++; if (lane(0) !== -1599360) begin failures++; $display("[TB] FAIL sign_lane0 got %0d want -1599360", lane(0)); end
        checks++; if (lane(31) !== 1586865) begin failures++; $display("[TB] FAIL sign_lane31 got %0d want 1586865", lane(31)); end
        checks++; if (lane(1) !== 0) begin failures++; $display("[TB] FAIL sign_lane1 got %0d want 0", lane(1)); end
        step();
    endtask

    task automatic test_gapped();
        int cyc;
        for (int k = 1; k <= ROWS; k++) begin
            beat(8'd1, 8'd1);
            checks++; if (beat_cnt !== 4'(k % ROWS)) begin failures++; $display("[TB] FAIL gap_beat_cnt beat %0d got %0d want %0d", k, beat_cnt, k % ROWS); end
            if (k < ROWS) begin
                step();
                checks++; if (sum_valid !== 1'b0) begin failures++; $display("[TB] FAIL gap_early_pulse beat %0d got %b want 0", k, sum_valid); end
                step();
            end
        end
        waitPulse(cyc);
        checks++; if (cyc !== 3) begin failures++; $display("[TB] FAIL gap_latency got %0d want 3", cyc); end
        checks++; if (lane(17) !== 49) begin failures++; $display("[TB] FAIL gap_sum got %0d want 49", lane(17)); end
        step();
    endtask

    task automatic test_back_to_back();
        int t[$];
        int v0[$];
        int v31[$];
        for (int i = 0; i < 24; i++) begin
            if (i < ROWS) begin
                conv_en = 1'b1; pixel = fillP(8'd1); conv_weight = fillW(8'd1);
            end else if (i < 2*ROWS) begin
                conv_en = 1'b1; pixel = fillP(8'd2); conv_weight = fillW(8'd3);
            end else begin
                conv_en = 1'b0;
            end
            step();
            if (sum_valid) begin
                t.push_back(i); v0.push_back(lane(0)); v31.push_back(lane(31));
            end
        end
        checks++; if (t.size() !== 2) begin failures++; $display("[TB] FAIL b2b_pulse_count got %0d want 2", t.size()); end
        if (t.size() == 2) begin
            checks++; if (t[0] !== 9) begin failures++; $display("[TB] FAIL b2b_first_time got %0d want 9", t[0]); end
            checks++; if (t[1] - t[0] !== 7) begin failures++; $display("[TB] FAIL b2b_spacing got %0d want 7", t[1] - t[0]); end
            checks++; if (v0[0] !== 49) begin failures++; $display("[TB] FAIL b2b_winA got %0d want 49", v0[0]); end
            checks++; if (v0[1] !== 294) begin failures++; $display("[TB] FAIL b2b_winB got %0d want 294", v0[1]); end
            checks++; if (v31[1] !== 294) begin failures++; $display("[TB] FAIL b2b_winB_lane31 got %0d want 294", v31[1]); end
        end
    endtask

    task automatic test_flush();
        int cyc, seen;
        for (int i = 0; i < 4; i++) beat(8'd1, 8'd1);
        flush = 1'b1;
        beat(8'd2, 8'd3);
        flush = 1'b0;
        checks++; if (beat_cnt !== 4'd0) begin failures++; $display("[TB] FAIL flush_beat_cnt got %0d want 0", beat_cnt); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL flush_busy got %b want 0", busy); end
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (sum_valid) seen++;
        end
        checks++; if (seen !== 0) begin failures++; $display("[TB] FAIL flush_no_pulse got %0d pulses want 0", seen); end
        checks++; if (lane(0) !== 294) begin failures++; $display("[TB] FAIL flush_hold got %0d want 294", lane(0)); end
        window(8'd1, 8'd1);
        waitPulse(cyc);
        checks++; if (cyc !== 3) begin failures++; $display("[TB] FAIL flush_next_latency got %0d want 3", cyc); end
        checks++; if (lane(0) !== 49) begin failures++; $display("[TB] FAIL flush_next_sum got %0d want 49", lane(0)); end
        step();
        // Flush landing on the edge that would raise sum_valid.
        window(8'd2, 8'd3);
        step();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++; if (sum_valid !== 1'b0) begin failures++; $display("[TB] FAIL flush_suppress got %b want 0", sum_valid); end
        checks++; if (lane(0) !== 49) begin failures++; $display("[TB] FAIL flush_suppress_hold got %0d want 49", lane(0)); end
        step();
    endtask

    task automatic test_async_reset();
        int seen;
        window(8'd1, 8'd1);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (sum_out !== '0) begin failures++; $display("[TB] FAIL areset_sum_out got %h want 0", sum_out); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL areset_busy got %b want 0", busy); end
        checks++; if (beat_cnt !== 4'd0) begin failures++; $display("[TB] FAIL areset_beat_cnt got %0d want 0", beat_cnt); end
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (sum_valid) seen++;
        end
        checks++; if (seen !== 0) begin failures++; $display("[TB] FAIL areset_no_pulse got %0d pulses want 0", seen); end
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_sign();
        test_gapped();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
